// File: rtl/mem_port_arbiter.sv
`default_nettype none
// =====================================================================
// mem_port_arbiter : shares one memory port between the core and debug
// Rev 1.0 - initial release
// =====================================================================
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int c_lat_w  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int c_wait_w = $clog2(MAX_WAIT + 1);
    localparam logic [c_lat_w-1:0]  c_lat_load = c_lat_w'(MEM_LAT - 1);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_owner_dbg;
    logic [c_lat_w-1:0]  r_lat_cnt;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_cpu_gnt;
    logic                r_dbg_gnt;

    logic w_any_req;
    logic w_pick_dbg;
    logic w_rd_done;

    // Debug wins when the core is quiet or once it has lost MAX_WAIT times in a row
    assign w_any_req  = cpu_req | dbg_req;
    assign w_pick_dbg = dbg_req & (~cpu_req | (r_wait_cnt >= c_wait_max));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner_dbg <= 1'b0;
            r_lat_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_gnt   <= 1'b0;
            r_dbg_gnt   <= 1'b0;
        end else begin
            // Memory strobes and grants are single-cycle unless re-armed below
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_gnt   <= 1'b0;
            r_dbg_gnt   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner_dbg <= w_pick_dbg;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_pick_dbg ? dbg_we    : cpu_we;
                        r_mem_addr  <= w_pick_dbg ? dbg_addr  : cpu_addr;
                        r_mem_wdata <= w_pick_dbg ? dbg_wdata : cpu_wdata;
                        r_cpu_gnt   <= ~w_pick_dbg;
                        r_dbg_gnt   <= w_pick_dbg;
                        if (w_pick_dbg) begin
                            r_wait_cnt <= '0;
                        end else if (dbg_req && (r_wait_cnt < c_wait_max)) begin
                            r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_mem_we) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_lat_cnt <= c_lat_load;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - c_lat_w'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read data is passed straight through from the macro in the completion cycle
    assign w_rd_done  = (r_state == S_WAIT) && (r_lat_cnt == '0);
    assign cpu_rvalid = w_rd_done & ~r_owner_dbg;
    assign dbg_rvalid = w_rd_done & r_owner_dbg;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

    assign cpu_gnt   = r_cpu_gnt;
    assign dbg_gnt   = r_dbg_gnt;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// =====================================================================
// tb_mem_port_arbiter : directed self-checking bench, MEM_LAT=2
// Rev 1.0 - initial release
// =====================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Two-cycle memory macro: address sampled at the end of the issue cycle
    logic [31:0] mem [0:63];
    logic [31:0] rd_p0, rd_p1;
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        rd_p0 <= mem[mem_addr[7:2]];
        rd_p1 <= rd_p0;
    end
    assign mem_rdata = rd_p1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we, busy} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000000",
                     {cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we, busy});
        end
        checks++;
        if ({mem_addr, mem_wdata, cpu_rdata, dbg_rdata} !== 128'b0) begin
            failures++;
            $display("FAIL reset_buses addr=%h wdata=%h crd=%h drd=%h exp=0",
                     mem_addr, mem_wdata, cpu_rdata, dbg_rdata);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_release busy=%b mem_en=%b exp=0,0", busy, mem_en);
        end
    endtask

    task automatic test_dbg_write();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'hDEADBEEF;
        tick();
        checks++;
        if ({dbg_gnt, cpu_gnt, mem_en, mem_we, busy} !== 5'b10111) begin
            failures++;
            $display("FAIL dbgwr_issue_flags got=%b exp=10111", {dbg_gnt, cpu_gnt, mem_en, mem_we, busy});
        end
        checks++;
        if (mem_addr !== 32'h20 || mem_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL dbgwr_issue_bus addr=%h wdata=%h exp=20,deadbeef", mem_addr, mem_wdata);
        end
        dbg_req = 1'b0;
        tick();
        checks++;
        if ({mem_en, mem_we, busy, dbg_gnt, dbg_rvalid} !== 5'b0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL dbgwr_after got=%b addr=%h exp=00000,0",
                     {mem_en, mem_we, busy, dbg_gnt, dbg_rvalid}, mem_addr);
        end
        tick();
        checks++;
        if (dbg_rvalid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL dbgwr_no_rvalid rvalid=%b busy=%b exp=0,0", dbg_rvalid, busy);
        end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1234;
        tick();
        checks++;
        if (cpu_gnt !== 1'b1 || mem_we !== 1'b1) begin
            failures++;
            $display("FAIL cpuwr_gnt gnt=%b we=%b exp=1,1", cpu_gnt, mem_we);
        end
        cpu_req = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_wdata = 32'h0;
        tick();
        checks++;
        if ({cpu_gnt, dbg_gnt, mem_en, mem_we, busy} !== 5'b10101 || mem_addr !== 32'h10) begin
            failures++;
            $display("FAIL cpurd_issue got=%b addr=%h exp=10101,10",
                     {cpu_gnt, dbg_gnt, mem_en, mem_we, busy}, mem_addr);
        end
        cpu_req = 1'b0;
        tick();
        checks++;
        if ({cpu_rvalid, mem_en, busy} !== 3'b001) begin
            failures++;
            $display("FAIL cpurd_wait got=%b exp=001", {cpu_rvalid, mem_en, busy});
        end
        tick();
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1234 || dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) begin
            failures++;
            $display("FAIL cpurd_data rvalid=%b rdata=%h drv=%b drd=%h exp=1,1234,0,0",
                     cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata);
        end
        tick();
        checks++;
        if (cpu_rvalid !== 1'b0 || busy !== 1'b0 || cpu_rdata !== 32'h0) begin
            failures++;
            $display("FAIL cpurd_done rvalid=%b busy=%b rdata=%h exp=0,0,0", cpu_rvalid, busy, cpu_rdata);
        end
    endtask

    task automatic test_arbitration();
        int n = 0;
        bit got [10];
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h44; dbg_wdata = 32'h2;
        for (int cyc = 0; cyc < 40 && n < 10; cyc++) begin
            tick();
            if (cpu_gnt || dbg_gnt) begin
                checks++;
                if (cpu_gnt && dbg_gnt) begin
                    failures++;
                    $display("FAIL arb_double_gnt cpu=%b dbg=%b exp=one", cpu_gnt, dbg_gnt);
                end else if (mem_addr !== (dbg_gnt ? 32'h44 : 32'h40)) begin
                    failures++;
                    $display("FAIL arb_addr got=%h dbg=%b", mem_addr, dbg_gnt);
                end
                got[n] = dbg_gnt;
                n++;
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        checks++;
        if (n != 10) begin
            failures++;
            $display("FAIL arb_timeout grants=%0d exp=10", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] !== (i % 5 == 4)) begin
                failures++;
                $display("FAIL arb_order idx=%0d got_dbg=%b exp_dbg=%b", i, got[i], (i % 5 == 4));
            end
        end
        tick();
    endtask

    task automatic test_rst_mid_read();
        bit seen = 1'b0;
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        tick();
        checks++;
        if (cpu_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rstrd_gnt got=%b exp=1", cpu_gnt);
        end
        cpu_req = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rstrd_busy got=%b exp=1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we, busy} !== 7'b0 ||
            cpu_rdata !== 32'h0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL rstrd_async got=%b rdata=%h addr=%h exp=0",
                     {cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we, busy}, cpu_rdata, mem_addr);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpu_rvalid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rstrd_stale got=activity exp=idle");
        end
        cpu_req = 1'b1;
        tick();
        checks++;
        if (cpu_gnt !== 1'b1 || mem_addr !== 32'h10) begin
            failures++;
            $display("FAIL rstrd_regnt gnt=%b addr=%h exp=1,10", cpu_gnt, mem_addr);
        end
        cpu_req = 1'b0;
        tick();
        tick();
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1234) begin
            failures++;
            $display("FAIL rstrd_reread rvalid=%b rdata=%h exp=1,1234", cpu_rvalid, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_dbg_alone_busy();
        int ncpu = 0;
        bit done = 1'b0;
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h48; cpu_wdata = 32'h3;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
        tick();
        checks++;
        if (cpu_gnt !== 1'b1) begin
            failures++;
            $display("FAIL dbga_pre1 cpu_gnt=%b exp=1", cpu_gnt);
        end
        tick();
        tick();
        checks++;
        if (cpu_gnt !== 1'b1) begin
            failures++;
            $display("FAIL dbga_pre2 cpu_gnt=%b exp=1", cpu_gnt);
        end
        cpu_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({dbg_gnt, cpu_gnt, mem_we} !== 3'b100 || mem_addr !== 32'h20) begin
            failures++;
            $display("FAIL dbga_gnt got=%b addr=%h exp=100,20", {dbg_gnt, cpu_gnt, mem_we}, mem_addr);
        end
        dbg_req = 1'b0;
        cpu_req = 1'b1; cpu_addr = 32'h4C;
        tick();
        checks++;
        if (cpu_gnt !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL dbga_busy1 cpu_gnt=%b busy=%b exp=0,1", cpu_gnt, busy);
        end
        tick();
        checks++;
        if ({dbg_rvalid, cpu_gnt, cpu_rvalid} !== 3'b100 || dbg_rdata !== 32'hDEADBEEF || cpu_rdata !== 32'h0) begin
            failures++;
            $display("FAIL dbga_rdata got=%b drd=%h crd=%h exp=100,deadbeef,0",
                     {dbg_rvalid, cpu_gnt, cpu_rvalid}, dbg_rdata, cpu_rdata);
        end
        tick();
        checks++;
        if (cpu_gnt !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL dbga_idle cpu_gnt=%b busy=%b exp=0,0", cpu_gnt, busy);
        end
        tick();
        checks++;
        if (cpu_gnt !== 1'b1 || mem_addr !== 32'h4C) begin
            failures++;
            $display("FAIL dbga_cpu_after gnt=%b addr=%h exp=1,4c", cpu_gnt, mem_addr);
        end
        // A cleared starvation counter lets the core win four more times
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h50;
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            tick();
            if (dbg_gnt) done = 1'b1;
            else if (cpu_gnt) ncpu++;
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        checks++;
        if (!done || ncpu != 4) begin
            failures++;
            $display("FAIL dbga_waitcnt dbg_won=%b cpu_wins=%0d exp=1,4", done, ncpu);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dbg_write();
        test_cpu_read();
        test_arbitration();
        test_rst_mid_read();
        test_dbg_alone_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
